// File: rtl/id_issue_stage.sv
// Decode-to-execute issue stage: ID/EXE pipeline register, per-register load scoreboard
// for load-use / WAW stalls, branch flush and a saturating stall-cycle counter.
module id_issue_stage #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned CW       = 24,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned WAW_CHK  = 1,
   parameter int unsigned CNTW     = 16
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [AW-1:0]   id_rs,
   input  logic [AW-1:0]   id_rt,
   input  logic [AW-1:0]   id_rn,
   input  logic            id_rs_used,
   input  logic            id_rt_used,
   input  logic            id_wreg,
   input  logic            id_m2reg,
   input  logic            id_wmem,
   input  logic [CW-1:0]   id_ctrl,
   input  logic [DW-1:0]   id_qa,
   input  logic [DW-1:0]   id_qb,
   input  logic [DW-1:0]   id_imm,
   input  logic [DW-1:0]   id_bpc,
   input  logic            flush,
   output logic            exe_valid,
   output logic [AW-1:0]   exe_rs,
   output logic [AW-1:0]   exe_rt,
   output logic [AW-1:0]   exe_d,
   output logic            exe_wreg,
   output logic            exe_m2reg,
   output logic            exe_wmem,
   output logic [CW-1:0]   exe_ctrl,
   output logic [DW-1:0]   exe_a,
   output logic [DW-1:0]   exe_b,
   output logic [DW-1:0]   exe_imm,
   output logic [DW-1:0]   exe_bpc,
   output logic [CNTW-1:0] stall_cnt
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned SBW  = $clog2(LOAD_LAT + 1);
   localparam logic [SBW-1:0] LAT_V = SBW'(LOAD_LAT);
   localparam logic WAW_EN = (WAW_CHK != 0);

   logic [SBW-1:0] sb_cnt [NREG];
   logic [NREG-1:0] busy;
   logic hazard;
   logic transfer;
   logic stall;
   logic sb_set;

   // Register 0 is hard-wired zero and can never hold a pending load.
   always_comb begin
      busy = '0;
      for (int r = 1; r < int'(NREG); r++) begin
         busy[r] = (sb_cnt[r] != '0);
      end
   end

   always_comb begin
      hazard = id_valid & ((id_rs_used & (id_rs != '0) & busy[id_rs])
                         | (id_rt_used & (id_rt != '0) & busy[id_rt])
                         | (WAW_EN & id_wreg & (id_rn != '0) & busy[id_rn]));
      transfer = id_valid & ~hazard & ~flush;
      stall    = id_valid &  hazard & ~flush;
      sb_set   = transfer & id_m2reg & id_wreg & (id_rn != '0);
   end

   assign id_ready = ~hazard | flush;

   // Operand fields follow ID every edge; only valid and write enables are gated.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         exe_valid <= 1'b0;
         exe_rs    <= '0;
         exe_rt    <= '0;
         exe_d     <= '0;
         exe_wreg  <= 1'b0;
         exe_m2reg <= 1'b0;
         exe_wmem  <= 1'b0;
         exe_ctrl  <= '0;
         exe_a     <= '0;
         exe_b     <= '0;
         exe_imm   <= '0;
         exe_bpc   <= '0;
      end else begin
         exe_valid <= transfer;
         exe_rs    <= id_rs;
         exe_rt    <= id_rt;
         exe_d     <= id_rn;
         exe_wreg  <= transfer & id_wreg;
         exe_m2reg <= transfer & id_m2reg;
         exe_wmem  <= transfer & id_wmem;
         exe_ctrl  <= id_ctrl;
         exe_a     <= id_qa;
         exe_b     <= id_qb;
         exe_imm   <= id_imm;
         exe_bpc   <= id_bpc;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

   // A new load overrides the countdown of its destination; flush leaves older loads pending.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int r = 0; r < int'(NREG); r++) begin
            sb_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < int'(NREG); r++) begin
            if (sb_set && (id_rn == AW'(r))) begin
               sb_cnt[r] <= LAT_V;
            end else if (sb_cnt[r] != '0) begin
               sb_cnt[r] <= sb_cnt[r] - SBW'(1);
            end
         end
      end
   end

endmodule
